// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl
//   Owns the fetch PC and sequences the 64-bit instruction-bus handshake
//   (inst_req / inst_addr_ok / inst_data_ok). It drops responses that belong
//   to a path abandoned by a branch/exception redirect, and delivers one or two
//   instructions per fetch through a one-entry output register.
//
//   Build option IFU_ADEL_CHECK_EN:
//     defined   - a misaligned pc (pc[1:0]!=0) never reaches the bus; it is
//                 reported once as a fault packet (fb_adel=1), and pc is held
//                 until the next redirect.
//     undefined - fb_adel is tied low and pc[1:0] is ignored.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        flush_req,
  input  logic        exception_pc_ena,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  input  logic        fb_ready,
  output logic        fb_valid,
  output logic [31:0] fb_pc,
  output logic [31:0] fb_inst0,
  output logic [31:0] fb_inst1,
  output logic        fb_inst1_valid,
  output logic        fb_adel
);

  // REQ: no transaction outstanding. WAIT: accepted request, response wanted.
  // DISCARD: accepted request whose response belongs to an abandoned path.
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // High only for the first cycle after reset release; suppresses the request.
  logic        boot_q;

  logic        fb_valid_q, fb_valid_d;
  logic [31:0] fb_pc_q, fb_pc_d;
  logic [31:0] fb_inst0_q, fb_inst0_d;
  logic [31:0] fb_inst1_q, fb_inst1_d;
  logic        fb_inst1_valid_q, fb_inst1_valid_d;

`ifdef IFU_ADEL_CHECK_EN
  logic        fb_adel_q, fb_adel_d;
  // Set once the fault packet for the current misaligned pc has been emitted.
  logic        adel_sent_q, adel_sent_d;
`endif

  logic        redir;
  logic        out_free;
  logic        can_start;
  logic        misalign;
  logic        issue;
  logic        adel_fire;
  logic        capture;

  logic [31:0] cap_inst0;
  logic [31:0] cap_inst1;
  logic        cap_inst1_valid;

  // Handshake qualifiers shared by the FSM and the output register.
  always_comb begin
    redir     = flush_req | exception_pc_ena;
    // The output register can take a packet if empty or draining this cycle;
    // this guarantees a response never finds fb_valid set.
    out_free  = ~fb_valid_q | fb_ready;
    can_start = (state_q == S_REQ) & out_free & ~redir & ~boot_q;
`ifdef IFU_ADEL_CHECK_EN
    misalign  = (pc_q[1:0] != 2'b00);
    adel_fire = can_start & misalign & ~adel_sent_q;
`else
    misalign  = 1'b0;
    adel_fire = 1'b0;
`endif
    issue     = can_start & ~misalign;
    capture   = (state_q == S_WAIT) & inst_data_ok & ~redir;
  end

  // Pick the instruction words out of the 64-bit beat according to pc[2]:
  // an upper-half pc only has one instruction left in the beat.
  always_comb begin
    cap_inst0       = inst_rdata[31:0];
    cap_inst1       = inst_rdata[63:32];
    cap_inst1_valid = 1'b1;
    if (pc_q[2]) begin
      cap_inst0       = inst_rdata[63:32];
      cap_inst1       = 32'h0;
      cap_inst1_valid = 1'b0;
    end
  end

  // Next-state and pc-update logic; pc moves only on a redirect or a response.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_REQ: begin
        if (redir) begin
          // inst_req is already low, so no handshake can complete here.
          pc_d = next_pc;
        end else if (issue & inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          // Captured or dropped, the transaction is complete; next_pc is the
          // sequential successor or the redirect target respectively.
          pc_d    = next_pc;
          state_d = S_REQ;
        end else if (redir) begin
          pc_d    = next_pc;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redir) begin
          pc_d = next_pc;
        end
        if (inst_data_ok) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Output register: a redirect kills a wrong-path packet before anything else.
  always_comb begin
    fb_valid_d       = fb_valid_q;
    fb_pc_d          = fb_pc_q;
    fb_inst0_d       = fb_inst0_q;
    fb_inst1_d       = fb_inst1_q;
    fb_inst1_valid_d = fb_inst1_valid_q;
    if (redir) begin
      fb_valid_d = 1'b0;
    end else if (capture) begin
      fb_valid_d       = 1'b1;
      fb_pc_d          = pc_q;
      fb_inst0_d       = cap_inst0;
      fb_inst1_d       = cap_inst1;
      fb_inst1_valid_d = cap_inst1_valid;
    end else if (adel_fire) begin
      fb_valid_d       = 1'b1;
      fb_pc_d          = pc_q;
      fb_inst0_d       = 32'h0;
      fb_inst1_d       = 32'h0;
      fb_inst1_valid_d = 1'b0;
    end else if (fb_ready) begin
      fb_valid_d = 1'b0;
    end
  end

  // FSM state, pc and post-reset request suppression.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      boot_q  <= 1'b0;
    end
  end

  // Fetch packet register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_valid_q       <= 1'b0;
      fb_pc_q          <= 32'h0;
      fb_inst0_q       <= 32'h0;
      fb_inst1_q       <= 32'h0;
      fb_inst1_valid_q <= 1'b0;
    end else begin
      fb_valid_q       <= fb_valid_d;
      fb_pc_q          <= fb_pc_d;
      fb_inst0_q       <= fb_inst0_d;
      fb_inst1_q       <= fb_inst1_d;
      fb_inst1_valid_q <= fb_inst1_valid_d;
    end
  end

`ifdef IFU_ADEL_CHECK_EN
  // Fault flag follows the packet it belongs to; one fault packet per bad pc.
  always_comb begin
    fb_adel_d   = fb_adel_q;
    adel_sent_d = adel_sent_q;
    if (redir) begin
      fb_adel_d   = 1'b0;
      adel_sent_d = 1'b0;
    end else if (capture) begin
      fb_adel_d = 1'b0;
    end else if (adel_fire) begin
      fb_adel_d   = 1'b1;
      adel_sent_d = 1'b1;
    end else if (fb_ready) begin
      fb_adel_d = 1'b0;
    end
  end

  // Address-error packet state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_adel_q   <= 1'b0;
      adel_sent_q <= 1'b0;
    end else begin
      fb_adel_q   <= fb_adel_d;
      adel_sent_q <= adel_sent_d;
    end
  end

  assign fb_adel = fb_adel_q;
`else
  assign fb_adel = 1'b0;
`endif

  assign pc             = pc_q;
  assign inst_req       = issue;
  assign inst_addr      = {pc_q[31:3], 3'b000};
  assign fb_valid       = fb_valid_q;
  assign fb_pc          = fb_pc_q;
  assign fb_inst0       = fb_inst0_q;
  assign fb_inst1       = fb_inst1_q;
  assign fb_inst1_valid = fb_inst1_valid_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Testbench for ifu_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model with a simple
// single-outstanding bus responder.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef IFU_ADEL_CHECK_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        flush_req;
  logic        exception_pc_ena;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic        fb_ready;
  logic        fb_valid;
  logic [31:0] fb_pc;
  logic [31:0] fb_inst0;
  logic [31:0] fb_inst1;
  logic        fb_inst1_valid;
  logic        fb_adel;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc               (pc),
    .next_pc          (next_pc),
    .flush_req        (flush_req),
    .exception_pc_ena (exception_pc_ena),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata),
    .fb_ready         (fb_ready),
    .fb_valid         (fb_valid),
    .fb_pc            (fb_pc),
    .fb_inst0         (fb_inst0),
    .fb_inst1         (fb_inst1),
    .fb_inst1_valid   (fb_inst1_valid),
    .fb_adel          (fb_adel)
  );

  int checks   = 0;
  int failures = 0;

  // Model: fetch pc, one accepted-but-unanswered request (good or stale),
  // and the packet the fetch buffer should be seeing.
  logic [31:0] m_pc;
  logic        m_pend;
  logic        m_stale;
  logic        m_first;
  logic        m_fbv;
  logic [31:0] m_fpc, m_i0, m_i1;
  logic        m_v1, m_adel, m_adel_sent;

  // Bus responder state.
  logic        bus_pend;
  int          bus_cnt;
  logic        g_hs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_pend = 1'b0; m_stale = 1'b0; m_first = 1'b1;
    m_fbv = 1'b0; m_fpc = '0; m_i0 = '0; m_i1 = '0; m_v1 = 1'b0;
    m_adel = 1'b0; m_adel_sent = 1'b0;
  endtask

  task automatic idle_in();
    flush_req = 1'b0; exception_pc_ena = 1'b0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = '0; fb_ready = 1'b0; next_pc = '0;
  endtask

  task automatic compare_model(input logic e_req);
    chk("inst_req", 64'(inst_req), 64'(e_req));
    chk("inst_addr", 64'(inst_addr), 64'({m_pc[31:3], 3'b000}));
    chk("pc", 64'(pc), 64'(m_pc));
    chk("fb_valid", 64'(fb_valid), 64'(m_fbv));
    if (m_fbv) begin
      chk("fb_pc", 64'(fb_pc), 64'(m_fpc));
      chk("fb_inst0", 64'(fb_inst0), 64'(m_i0));
      chk("fb_inst1", 64'(fb_inst1), 64'(m_i1));
      chk("fb_inst1_valid", 64'(fb_inst1_valid), 64'(m_v1));
      chk("fb_adel", 64'(fb_adel), 64'(m_adel));
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic cyc(input logic fl, input logic ex, input logic [31:0] tgt,
                     input logic aok, input logic dok, input logic [63:0] rd,
                     input logic rdy);
    logic        redir, mis, can_out, idle, e_req, e_adel, cap;
    logic [31:0] np, n_pc, n_fpc, n_i0, n_i1;
    logic        n_pend, n_stale, n_fbv, n_v1, n_adel, n_sent;
    redir = fl | ex;
    np = redir ? tgt : m_pc + (m_pc[2] ? 32'd4 : 32'd8);
    flush_req = fl; exception_pc_ena = ex; inst_addr_ok = aok;
    inst_data_ok = dok; inst_rdata = rd; fb_ready = rdy; next_pc = np;
    #1;
    mis     = ADEL_EN && (m_pc[1:0] != 2'b00);
    can_out = !m_fbv || rdy;
    idle    = !m_pend && !m_stale;
    e_req   = idle && can_out && !redir && !m_first && !mis;
    e_adel  = idle && can_out && !redir && !m_first && mis && !m_adel_sent;
    compare_model(e_req);
    g_hs = inst_req && aok;

    n_pc    = (redir || (m_pend && dok)) ? np : m_pc;
    cap     = m_pend && dok && !redir;
    n_pend  = m_pend;
    n_stale = m_stale;
    if (e_req && aok) n_pend = 1'b1;
    else if (m_pend && (dok || redir)) begin
      n_pend  = 1'b0;
      n_stale = redir && !dok;
    end
    if (m_stale && dok) n_stale = 1'b0;

    n_fbv = m_fbv; n_fpc = m_fpc; n_i0 = m_i0; n_i1 = m_i1; n_v1 = m_v1;
    n_adel = m_adel; n_sent = m_adel_sent;
    if (redir) begin
      n_fbv = 1'b0; n_sent = 1'b0;
    end else if (cap) begin
      n_fbv = 1'b1; n_fpc = m_pc; n_adel = 1'b0;
      if (m_pc[2]) begin n_i0 = rd[63:32]; n_i1 = '0; n_v1 = 1'b0; end
      else begin n_i0 = rd[31:0]; n_i1 = rd[63:32]; n_v1 = 1'b1; end
    end else if (e_adel) begin
      n_fbv = 1'b1; n_fpc = m_pc; n_i0 = '0; n_i1 = '0; n_v1 = 1'b0;
      n_adel = 1'b1; n_sent = 1'b1;
    end else if (rdy) begin
      n_fbv = 1'b0;
    end

    @(posedge clk);
    m_pc = n_pc; m_pend = n_pend; m_stale = n_stale; m_first = 1'b0;
    m_fbv = n_fbv; m_fpc = n_fpc; m_i0 = n_i0; m_i1 = n_i1; m_v1 = n_v1;
    m_adel = n_adel; m_adel_sent = n_sent;
    @(negedge clk);
  endtask

  // Asynchronous reset: effects visible before any clock edge.
  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pc", 64'(pc), 64'(RESET_PC));
    chk("rst_fb_valid", 64'(fb_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot_no_req", 64'(inst_req), 64'd0);
    bus_pend = 1'b0;
    bus_cnt  = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    model_reset();
    bus_pend = 1'b0; bus_cnt = 0; g_hs = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_fb_pc", 64'(fb_pc), 64'd0);
    chk("rst_fb_inst0", 64'(fb_inst0), 64'd0);
    chk("rst_fb_inst1_valid", 64'(fb_inst1_valid), 64'd0);

    // Aligned fetch after reset: two instructions.
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    chk("t1_req", 64'(inst_req), 64'd1);
    chk("t1_addr", 64'(inst_addr), 64'h0000_0000_BFC0_0000);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h11111111_22222222, 1'b1);
    chk("t1_fb_valid", 64'(fb_valid), 64'd1);
    chk("t1_fb_pc", 64'(fb_pc), 64'h0000_0000_BFC0_0000);
    chk("t1_inst0", 64'(fb_inst0), 64'h0000_0000_2222_2222);
    chk("t1_inst1", 64'(fb_inst1), 64'h0000_0000_1111_1111);
    chk("t1_inst1_valid", 64'(fb_inst1_valid), 64'd1);
    chk("t1_pc", 64'(pc), 64'h0000_0000_BFC0_0008);

    // Upper-half pc: one instruction, advance by 4.
    cyc(1'b1, 1'b0, 32'hBFC0_0004, 1'b0, 1'b0, '0, 1'b1);
    chk("t2_redir_pc", 64'(pc), 64'h0000_0000_BFC0_0004);
    chk("t2_fb_cleared", 64'(fb_valid), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    chk("t2_inst0", 64'(fb_inst0), 64'h0000_0000_AAAA_BBBB);
    chk("t2_inst1_valid", 64'(fb_inst1_valid), 64'd0);
    chk("t2_fb_pc", 64'(fb_pc), 64'h0000_0000_BFC0_0004);
    chk("t2_pc", 64'(pc), 64'h0000_0000_BFC0_0008);

    // Fetch-buffer backpressure holds everything.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      chk("t3_stall_req", 64'(inst_req), 64'd0);
      chk("t3_stall_pc", 64'(pc), 64'h0000_0000_BFC0_0008);
      chk("t3_stall_inst0", 64'(fb_inst0), 64'h0000_0000_AAAA_BBBB);
      chk("t3_stall_valid", 64'(fb_valid), 64'd1);
    end
    fb_ready = 1'b1;
    #1;
    chk("t3_release_req", 64'(inst_req), 64'd1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);

    // Redirect while waiting: late response is dropped.
    cyc(1'b1, 1'b0, 32'h8000_1000, 1'b0, 1'b0, '0, 1'b1);
    chk("t4_pc", 64'(pc), 64'h0000_0000_8000_1000);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
    chk("t4_dropped", 64'(fb_valid), 64'd0);
    chk("t4_addr", 64'(inst_addr), 64'h0000_0000_8000_1000);
    chk("t4_req", 64'(inst_req), 64'd1);

    // Redirect coincident with the response.
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, 32'h8000_2000, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    chk("t5_dropped", 64'(fb_valid), 64'd0);
    chk("t5_pc", 64'(pc), 64'h0000_0000_8000_2000);
    idle_in();
    #1;
    chk("t5_req", 64'(inst_req), 64'd1);
    chk("t5_addr", 64'(inst_addr), 64'h0000_0000_8000_2000);

    // Reset in the middle of a transaction.
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    do_reset();

`ifdef IFU_ADEL_CHECK_EN
    // Misaligned exception target raises a fault packet instead of a request.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 32'h8000_0182, 1'b0, 1'b0, '0, 1'b1);
    chk("t6_pc", 64'(pc), 64'h0000_0000_8000_0182);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("t6_fb_valid", 64'(fb_valid), 64'd1);
    chk("t6_adel", 64'(fb_adel), 64'd1);
    chk("t6_fb_pc", 64'(fb_pc), 64'h0000_0000_8000_0182);
    chk("t6_inst1_valid", 64'(fb_inst1_valid), 64'd0);
    chk("t6_no_req", 64'(inst_req), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 32'h8000_0180, 1'b0, 1'b0, '0, 1'b1);
    idle_in();
    #1;
    chk("t6_resume_req", 64'(inst_req), 64'd1);
    chk("t6_resume_addr", 64'(inst_addr), 64'h0000_0000_8000_0180);
`endif

    // Randomized traffic with a single-outstanding bus responder.
    for (int i = 0; i < 4000; i++) begin
      logic        fl, ex, aok, dok, rdy;
      logic [31:0] tgt;
      logic [63:0] rd;
      if (i % 1000 == 999) begin
        do_reset();
      end else begin
        fl  = ($urandom_range(0, 11) == 0);
        ex  = ($urandom_range(0, 23) == 0);
        tgt = $urandom & 32'hFFFF_FFFC;
        if (ADEL_EN && $urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
        aok = ($urandom_range(0, 2) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        rd  = {$urandom, $urandom};
        dok = bus_pend && (bus_cnt == 0);
        cyc(fl, ex, tgt, aok, dok, rd, rdy);
        if (dok) bus_pend = 1'b0;
        if (g_hs) begin
          bus_pend = 1'b1;
          bus_cnt  = $urandom_range(0, 3);
        end else if (bus_pend && bus_cnt > 0) begin
          bus_cnt--;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
